unidade_multdiv: RTL



---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_if.sv | 14 +
 rtl/multdiv_sinal.sv | 40 ++++
 rtl/unidade_multdiv.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op encodings, FSM states,
// default width and iteration count.
package multdiv_pkg;

  localparam int SIZE_DEF = 32;
  localparam int N_ITER   = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/multdiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface multdiv_if #(parameter int SIZE = 32);
  logic            start;
  logic [2:0]      op;
  logic [SIZE-1:0] Data1;
  logic [SIZE-1:0] Data2;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] hi;
  logic [SIZE-1:0] lo;

  modport master (output start, op, Data1, Data2, input busy, done, hi, lo);
  modport slave  (input start, op, Data1, Data2, output busy, done, hi, lo);
endinterface

// File: rtl/multdiv_sinal.sv
// Combinational sign handling: operand magnitudes going in, sign restoration of the
// raw 64-bit result coming out (whole-product negate, or per-half for divide).
module multdiv_sinal #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  input  logic              signed_en,
  output logic              sgn_a,
  output logic              sgn_b,
  output logic [SIZE-1:0]   mag_a,
  output logic [SIZE-1:0]   mag_b,
  input  logic [2*SIZE-1:0] val,
  input  logic              neg_full,
  input  logic              neg_hi,
  input  logic              neg_lo,
  output logic [2*SIZE-1:0] res
);

  logic [SIZE-1:0] val_hi;
  logic [SIZE-1:0] val_lo;

  assign sgn_a  = signed_en & a[SIZE-1];
  assign sgn_b  = signed_en & b[SIZE-1];
  assign mag_a  = sgn_a ? -a : a;
  assign mag_b  = sgn_b ? -b : b;
  assign val_hi = val[2*SIZE-1:SIZE];
  assign val_lo = val[SIZE-1:0];

  always_comb begin
    res = val;
    if (neg_full) begin
      res = -val;
    end else begin
      res[2*SIZE-1:SIZE] = neg_hi ? -val_hi : val_hi;
      res[SIZE-1:0]      = neg_lo ? -val_lo : val_lo;
    end
  end

endmodule

// File: rtl/unidade_multdiv.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Define MULTDIV_DIV_EN to build DIV/DIVU; otherwise they behave as reserved ops.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO complete here
// S_CALC | one shift-add / restore step per cycle, SIZE cycles
// S_FIX  | sign correction, hi/lo write, done pulse
module unidade_multdiv
  import multdiv_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam int CW = $clog2(SIZE);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*SIZE-1:0] acc;
  logic [SIZE-1:0]   opnd;
  logic              sign_a, sign_b;
  logic              done_r;
  logic [SIZE-1:0]   hi_r, lo_r;

  logic              is_div, div_zero;
  logic              accept_mul, accept_div, accept;
  logic              signed_op;
  logic              sgn_a, sgn_b;
  logic [SIZE-1:0]   mag_a, mag_b;
  logic [2*SIZE-1:0] fixed;
  logic [SIZE:0]     mul_sum;
  logic [2*SIZE-1:0] mul_next;

  assign signed_op  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign accept_mul = (state == S_IDLE) && bus.start &&
                      ((bus.op == OP_MULT) || (bus.op == OP_MULTU));
  assign accept     = accept_mul || accept_div;

  multdiv_sinal #(.SIZE(SIZE)) u_sinal (
    .a        (bus.Data1),
    .b        (bus.Data2),
    .signed_en(signed_op),
    .sgn_a    (sgn_a),
    .sgn_b    (sgn_b),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .val      (acc),
    .neg_full (!is_div && (sign_a ^ sign_b)),
    .neg_hi   (is_div && sign_a),
    .neg_lo   (is_div && (sign_a ^ sign_b)),
    .res      (fixed)
  );

  // Multiplier sits in the low half and drains out as the partial product shifts in.
  assign mul_sum  = {1'b0, acc[2*SIZE-1:SIZE]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[SIZE-1:1]};

`ifdef MULTDIV_DIV_EN
  logic [SIZE:0]     div_part, div_trial;
  logic [2*SIZE-1:0] div_next;

  assign accept_div = (state == S_IDLE) && bus.start &&
                      ((bus.op == OP_DIV) || (bus.op == OP_DIVU));
  assign div_part   = acc[2*SIZE-1:SIZE-1];
  assign div_trial  = div_part - {1'b0, opnd};
  assign div_next   = div_trial[SIZE] ? {div_part[SIZE-1:0], acc[SIZE-2:0], 1'b0}
                                      : {div_trial[SIZE-1:0], acc[SIZE-2:0], 1'b1};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      is_div   <= accept_div;
      div_zero <= accept_div && (bus.Data2 == '0);
    end
  end
`else
  assign accept_div = 1'b0;
  assign is_div     = 1'b0;
  assign div_zero   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && bus.op == OP_MTHI) hi_r <= bus.Data1;
          if (bus.start && bus.op == OP_MTLO) lo_r <= bus.Data1;
          if (accept) begin
            opnd   <= accept_div ? mag_b : mag_a;
            acc    <= {{SIZE{1'b0}}, (accept_div ? mag_a : mag_b)};
            sign_a <= sgn_a;
            sign_b <= sgn_b;
            cnt    <= CW'(N_ITER - 1);
          end
        end
        S_CALC: begin
`ifdef MULTDIV_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          hi_r   <= fixed[2*SIZE-1:SIZE];
          lo_r   <= div_zero ? '1 : fixed[SIZE-1:0];
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == S_CALC) || (state == S_FIX);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
